// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine host side: character
// constants, default buffer depths and the feeder state encoding.
package sme_pkg;

   localparam logic [7:0] DOT    = 8'h2E;
   localparam logic [7:0] STAR   = 8'h2A;
   localparam logic [7:0] CARET  = 8'h5E;
   localparam logic [7:0] DOLLAR = 8'h24;
   localparam logic [7:0] SPACE  = 8'h20;

   localparam int STR_MAX_DEF = 32;
   localparam int PAT_MAX_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_STR,
      ST_SEND_PAT,
      ST_WAIT_RES,
      ST_REPORT
   } feeder_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sme_char_buf.sv
// Depth-N character buffer: append-only write at the current length,
// sticky overflow on a write to a full buffer, asynchronous read port.
module sme_char_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          wr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [LW-1:0] len,
   output logic          ovf
);

   logic [7:0]    mem [DEPTH];
   logic [LW-1:0] len_reg;
   logic          ovf_reg;
   logic          full;

   assign full    = (len_reg == LW'(DEPTH));
   assign rd_data = mem[rd_addr];
   assign len     = len_reg;
   assign ovf     = ovf_reg;

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr && !clr && !full)
         mem[AW'(len_reg)] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_reg <= '0;
         ovf_reg <= 1'b0;
      end else if (clr) begin
         len_reg <= '0;
         ovf_reg <= 1'b0;
      end else if (wr) begin
         if (full)
            ovf_reg <= 1'b1;
         else
            len_reg <= len_reg + LW'(1);
      end
   end

endmodule

// File: rtl/sme_host_feeder.sv
// Host transmitter for the string-match engine: buffers a string and a pattern,
// streams them with isstring/ispattern framing and captures the engine result.
// Optional WAIT_RES timeout is enabled by defining SME_FEEDER_TIMEOUT_EN.
module sme_host_feeder
   import sme_pkg::*;
#(
   parameter int          STR_MAX = STR_MAX_DEF,
   parameter int          PAT_MAX = PAT_MAX_DEF,
   parameter logic [10:0] TO_CYC  = 11'd1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_valid,
   input  logic       ld_sel,
   input  logic       ld_clr,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   input  logic       start,
   input  logic       keep_str,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       valid,
   input  logic       match,
   input  logic [4:0] match_index,
   output logic       busy,
   output logic       res_valid,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       err,
   output logic       ovf
);

   localparam int IW  = $clog2(max_int(STR_MAX, PAT_MAX) + 1);
   localparam int SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
   localparam int PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
   localparam int SLW = $clog2(STR_MAX + 1);
   localparam int PLW = $clog2(PAT_MAX + 1);

   feeder_state_t state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic [7:0]    chardata_reg, chardata_next;
   logic          isstring_reg, isstring_next;
   logic          ispattern_reg, ispattern_next;
   logic          res_valid_reg, res_valid_next;
   logic          res_match_reg, res_match_next;
   logic [4:0]    res_index_reg, res_index_next;
   logic          err_reg, err_next;
   logic          str_sent_reg, str_sent_next;
   logic          ld_ready_reg, busy_reg, ovf_reg;

   logic [SLW-1:0] s_len;
   logic [PLW-1:0] p_len;
   logic [IW-1:0]  slen, plen;
   logic [7:0]     s_rd, p_rd;
   logic [SAW-1:0] s_addr;
   logic [PAW-1:0] p_addr;
   logic           s_ovf, p_ovf, ld_go, clr_go;

   // Buffers are only touched while idle so a stream in flight never changes.
   assign ld_go  = ld_ready_reg & ld_valid & ~ld_clr;
   assign clr_go = ld_ready_reg & ld_clr;
   assign slen   = IW'(s_len);
   assign plen   = IW'(p_len);
   assign s_addr = SAW'(idx_reg);
   // The pattern read address sits at 0 until SEND_PAT so pbuf[0] is ready
   // for the seamless string-to-pattern handover.
   assign p_addr = (state_reg == ST_SEND_PAT) ? PAW'(idx_reg) : '0;

   sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_go & ~ld_sel),
      .wr      (ld_go & ~ld_sel),
      .wr_data (ld_data),
      .rd_addr (s_addr),
      .rd_data (s_rd),
      .len     (s_len),
      .ovf     (s_ovf)
   );

   sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr_go & ld_sel),
      .wr      (ld_go & ld_sel),
      .wr_data (ld_data),
      .rd_addr (p_addr),
      .rd_data (p_rd),
      .len     (p_len),
      .ovf     (p_ovf)
   );

`ifdef SME_FEEDER_TIMEOUT_EN
   logic [10:0] cnt_reg, cnt_next;
   always_ff @(posedge clk) begin
      if (reset) cnt_reg <= '0;
      else       cnt_reg <= cnt_next;
   end
`else
   logic unused_to_cyc;
   assign unused_to_cyc = ^TO_CYC;
`endif

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      chardata_next  = 8'd0;
      isstring_next  = 1'b0;
      ispattern_next = 1'b0;
      res_valid_next = 1'b0;
      res_match_next = res_match_reg;
      res_index_next = res_index_reg;
      err_next       = 1'b0;
      str_sent_next  = str_sent_reg;
`ifdef SME_FEEDER_TIMEOUT_EN
      cnt_next       = cnt_reg;
`endif
      if (clr_go && !ld_sel)
         str_sent_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            idx_next = '0;
            if (start) begin
               if ((plen == '0) || (!keep_str && slen == '0) || (keep_str && !str_sent_reg)) begin
                  err_next = 1'b1;
               end else if (!keep_str) begin
                  state_next    = ST_SEND_STR;
                  isstring_next = 1'b1;
                  chardata_next = s_rd;
                  idx_next      = IW'(1);
               end else begin
                  state_next     = ST_SEND_PAT;
                  ispattern_next = 1'b1;
                  chardata_next  = p_rd;
                  idx_next       = IW'(1);
               end
            end
         end
         ST_SEND_STR: begin
            if (idx_reg < slen) begin
               isstring_next = 1'b1;
               chardata_next = s_rd;
               idx_next      = idx_reg + IW'(1);
            end else begin
               state_next     = ST_SEND_PAT;
               ispattern_next = 1'b1;
               chardata_next  = p_rd;
               idx_next       = IW'(1);
            end
         end
         ST_SEND_PAT: begin
            if (idx_reg < plen) begin
               ispattern_next = 1'b1;
               chardata_next  = p_rd;
               idx_next       = idx_reg + IW'(1);
            end else begin
               state_next    = ST_WAIT_RES;
               str_sent_next = 1'b1;
               idx_next      = '0;
`ifdef SME_FEEDER_TIMEOUT_EN
               cnt_next      = '0;
`endif
            end
         end
         ST_WAIT_RES: begin
            if (valid) begin
               state_next     = ST_REPORT;
               res_valid_next = 1'b1;
               res_match_next = match;
               res_index_next = match_index;
            end
`ifdef SME_FEEDER_TIMEOUT_EN
            else if (cnt_reg == TO_CYC - 11'd1) begin
               state_next    = ST_IDLE;
               err_next      = 1'b1;
               str_sent_next = 1'b0;
            end else begin
               cnt_next = cnt_reg + 11'd1;
            end
`endif
         end
         ST_REPORT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         chardata_reg  <= 8'd0;
         isstring_reg  <= 1'b0;
         ispattern_reg <= 1'b0;
         res_valid_reg <= 1'b0;
         res_match_reg <= 1'b0;
         res_index_reg <= 5'd0;
         err_reg       <= 1'b0;
         str_sent_reg  <= 1'b0;
         ld_ready_reg  <= 1'b1;
         busy_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         chardata_reg  <= chardata_next;
         isstring_reg  <= isstring_next;
         ispattern_reg <= ispattern_next;
         res_valid_reg <= res_valid_next;
         res_match_reg <= res_match_next;
         res_index_reg <= res_index_next;
         err_reg       <= err_next;
         str_sent_reg  <= str_sent_next;
         ld_ready_reg  <= (state_next == ST_IDLE);
         busy_reg      <= (state_next != ST_IDLE);
         ovf_reg       <= s_ovf | p_ovf;
      end
   end

   assign chardata  = chardata_reg;
   assign isstring  = isstring_reg;
   assign ispattern = ispattern_reg;
   assign res_valid = res_valid_reg;
   assign res_match = res_match_reg;
   assign res_index = res_index_reg;
   assign err       = err_reg;
   assign ld_ready  = ld_ready_reg;
   assign busy      = busy_reg;
   assign ovf       = ovf_reg;

endmodule
